// File: rtl/uart_rx_cmd_parser.sv
// Turns the UART receiver's byte stream into register write/read strobes.
// Frames are {WR_CMD, addr, data} and {RD_CMD, addr}. Bad opcodes, bad addresses and stalled frames return the parser to IDLE.
module uart_rx_cmd_parser #(
    parameter int              DATA_WIDTH     = 8,
    parameter int              ADDR_WIDTH     = 4,
    parameter int              TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] WR_CMD   = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD   = 8'hBB
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  cmd_error,
    output logic                  timeout_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             addr_ok;

    // Any set bit above the address field means the register does not exist.
    assign addr_ok = (RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH] == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            busy          <= 1'b0;
            cnt           <= '0;
            WrEn          <= 1'b0;
            RdEn          <= 1'b0;
            cmd_error     <= 1'b0;
            timeout_error <= 1'b0;
            Address       <= '0;
            WrData        <= '0;
        end else begin
            WrEn          <= 1'b0;
            RdEn          <= 1'b0;
            cmd_error     <= 1'b0;
            timeout_error <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state <= WR_ADDR;
                        busy  <= 1'b1;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state <= RD_ADDR;
                        busy  <= 1'b1;
                    end else begin
                        cmd_error <= 1'b1;
                    end
                end
            end else if (RX_D_VLD) begin
                // A byte on the last allowed cycle still beats the timeout.
                cnt <= '0;
                case (state)
                    WR_ADDR: begin
                        if (addr_ok) begin
                            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state   <= WR_DATA;
                        end else begin
                            cmd_error <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                    WR_DATA: begin
                        WrData <= RX_P_DATA;
                        WrEn   <= 1'b1;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                    RD_ADDR: begin
                        if (addr_ok) begin
                            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            RdEn    <= 1'b1;
                        end else begin
                            cmd_error <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (cnt == CNT_MAX) begin
                timeout_error <= 1'b1;
                cnt           <= '0;
                state         <= IDLE;
                busy          <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed bench for uart_rx_cmd_parser: a byte table with expected outputs,
// plus hand-written timeout and mid-frame reset sequences.
module tb_uart_rx_cmd_parser;

    localparam int TO = 16;

    logic       TX_CLK_TB = 1'b0;
    logic       rst;
    logic [7:0] rx_p_data;
    logic       rx_d_vld;
    logic       wr_en, rd_en, cmd_error, timeout_error, busy;
    logic [3:0] address;
    logic [7:0] wr_data;

    int tests = 0;
    int fails = 0;

    always #5 TX_CLK_TB = ~TX_CLK_TB;

    uart_rx_cmd_parser #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO),
        .WR_CMD(8'hAA), .RD_CMD(8'hBB)
    ) dut (
        .CLK(TX_CLK_TB), .RST(rst), .RX_P_DATA(rx_p_data), .RX_D_VLD(rx_d_vld),
        .WrEn(wr_en), .RdEn(rd_en), .Address(address), .WrData(wr_data),
        .cmd_error(cmd_error), .timeout_error(timeout_error), .busy(busy)
    );

    typedef struct {
        int         gap;
        logic [7:0] data;
        logic       wr, rd, cerr, bsy;
        logic [3:0] addr;
        logic [7:0] wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one byte for one cycle; outputs are sampled 1ns after the edge that takes it.
    task automatic send_byte(input logic [7:0] b);
        @(negedge TX_CLK_TB);
        rx_p_data = b;
        rx_d_vld  = 1'b1;
        @(posedge TX_CLK_TB);
        #1;
        rx_d_vld  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge TX_CLK_TB);
        #1;
    endtask

    function automatic vec_t mk(input int g, input logic [7:0] d, input logic w, input logic r,
                                input logic c, input logic b, input logic [3:0] a, input logic [7:0] wd);
        vec_t v;
        v.gap = g; v.data = d; v.wr = w; v.rd = r; v.cerr = c; v.bsy = b; v.addr = a; v.wdata = wd;
        return v;
    endfunction

    initial begin
        logic prev_busy;
        logic any_strobe;
        logic saw_wr;
        int   hit;

        //            gap data  wr rd ce busy addr wdata
        vecs.push_back(mk(10, 8'hAA, 0, 0, 0, 1, 4'h0, 8'h00));
        vecs.push_back(mk(10, 8'h05, 0, 0, 0, 1, 4'h5, 8'h00));
        vecs.push_back(mk(10, 8'h3C, 1, 0, 0, 0, 4'h5, 8'h3C));
        vecs.push_back(mk( 2, 8'hBB, 0, 0, 0, 1, 4'h5, 8'h3C));
        vecs.push_back(mk( 2, 8'h0F, 0, 1, 0, 0, 4'hF, 8'h3C));
        vecs.push_back(mk( 2, 8'hBB, 0, 0, 0, 1, 4'hF, 8'h3C));
        vecs.push_back(mk( 2, 8'h10, 0, 0, 1, 0, 4'hF, 8'h3C));
        vecs.push_back(mk( 2, 8'h55, 0, 0, 1, 0, 4'hF, 8'h3C));
        vecs.push_back(mk( 1, 8'hAA, 0, 0, 0, 1, 4'hF, 8'h3C));
        vecs.push_back(mk( 1, 8'h01, 0, 0, 0, 1, 4'h1, 8'h3C));
        vecs.push_back(mk( 1, 8'hFF, 1, 0, 0, 0, 4'h1, 8'hFF));
        vecs.push_back(mk( 1, 8'hAA, 0, 0, 0, 1, 4'h1, 8'hFF));
        vecs.push_back(mk( 1, 8'hAA, 0, 0, 1, 0, 4'h1, 8'hFF));  // opcode as address byte
        vecs.push_back(mk( 1, 8'hAA, 0, 0, 0, 1, 4'h1, 8'hFF));
        vecs.push_back(mk( 1, 8'h02, 0, 0, 0, 1, 4'h2, 8'hFF));
        vecs.push_back(mk( 1, 8'h11, 1, 0, 0, 0, 4'h2, 8'h11));
        vecs.push_back(mk( 0, 8'hBB, 0, 0, 0, 1, 4'h2, 8'h11));  // back-to-back
        vecs.push_back(mk( 1, 8'h02, 0, 1, 0, 0, 4'h2, 8'h11));
        vecs.push_back(mk( 3, 8'hAA, 0, 0, 0, 1, 4'h2, 8'h11));
        vecs.push_back(mk( 1, 8'h0F, 0, 0, 0, 1, 4'hF, 8'h11));
        vecs.push_back(mk( 1, 8'h00, 1, 0, 0, 0, 4'hF, 8'h00));
        vecs.push_back(mk( 1, 8'hBB, 0, 0, 0, 1, 4'hF, 8'h00));
        vecs.push_back(mk( 1, 8'h00, 0, 1, 0, 0, 4'h0, 8'h00));

        rst = 1'b1; rx_d_vld = 1'b0; rx_p_data = 8'h00;
        #1;
        check("reset_outputs", {wr_en, rd_en, cmd_error, timeout_error, busy, address, wr_data},
              {5'b0, 4'h0, 8'h00});
        repeat (3) @(posedge TX_CLK_TB);
        @(negedge TX_CLK_TB);
        rst = 1'b0;

        prev_busy = 1'b0;
        foreach (vecs[i]) begin
            any_strobe = 1'b0;
            for (int g = 0; g < vecs[i].gap; g++) begin
                idle_cycle();
                if (wr_en || rd_en || cmd_error || timeout_error || busy !== prev_busy)
                    any_strobe = 1'b1;
            end
            if (vecs[i].gap > 0)
                check($sformatf("v%0d_gap_quiet", i), {31'b0, any_strobe}, 32'd0);
            send_byte(vecs[i].data);
            check($sformatf("v%0d_strobes", i), {wr_en, rd_en, cmd_error, timeout_error, busy},
                  {vecs[i].wr, vecs[i].rd, vecs[i].cerr, 1'b0, vecs[i].bsy});
            check($sformatf("v%0d_addr", i), address, vecs[i].addr);
            check($sformatf("v%0d_wdata", i), wr_data, vecs[i].wdata);
            prev_busy = vecs[i].bsy;
        end
        idle_cycle();
        check("tail_strobes_clear", {wr_en, rd_en, cmd_error, timeout_error, busy}, 5'b0);

        // Opcode followed by silence: abort exactly TO edges after the opcode edge.
        send_byte(8'hAA);
        hit = 0; saw_wr = 1'b0;
        for (int c = 1; c <= 40 && hit == 0; c++) begin
            idle_cycle();
            if (wr_en) saw_wr = 1'b1;
            if (timeout_error) begin
                hit = c;
                check("timeout_busy_drop", {31'b0, busy}, 32'd0);
            end
        end
        check("timeout_latency", hit, TO);
        check("timeout_no_wren", {31'b0, saw_wr}, 32'd0);
        idle_cycle();
        check("timeout_one_cycle", {31'b0, timeout_error}, 32'd0);

        // Byte on the last allowed cycle (counter at TO-1) keeps the frame alive.
        send_byte(8'hAA);
        any_strobe = 1'b0;
        for (int c = 0; c < TO - 1; c++) begin
            idle_cycle();
            if (timeout_error || !busy) any_strobe = 1'b1;
        end
        check("boundary_quiet", {31'b0, any_strobe}, 32'd0);
        send_byte(8'h05);
        check("boundary_no_timeout", {timeout_error, busy, address}, {1'b0, 1'b1, 4'h5});
        repeat (TO - 1) idle_cycle();
        send_byte(8'h3C);
        check("boundary_write", {wr_en, timeout_error, busy, address, wr_data},
              {1'b1, 1'b0, 1'b0, 4'h5, 8'h3C});

        // Reset in the middle of a write frame.
        send_byte(8'hAA);
        send_byte(8'h03);
        check("pre_reset_busy", {busy, address}, {1'b1, 4'h3});
        @(negedge TX_CLK_TB);
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", {wr_en, rd_en, cmd_error, timeout_error, busy, address, wr_data},
              {5'b0, 4'h0, 8'h00});
        @(posedge TX_CLK_TB);
        #1;
        check("held_reset_outputs", {wr_en, rd_en, cmd_error, timeout_error, busy, address, wr_data},
              {5'b0, 4'h0, 8'h00});
        @(negedge TX_CLK_TB);
        rst = 1'b0;
        send_byte(8'h7E);
        check("post_reset_opcode_err", {wr_en, rd_en, cmd_error, busy}, 4'b0010);
        idle_cycle();
        check("post_reset_quiet", {wr_en, rd_en, cmd_error, busy}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
